packet_tx_scheduler: RTL and testbench

PACKET_TX_SCHEDULER -- requirements
Module: packet_tx_scheduler

---
 rtl/packet_tx_scheduler_if.sv | 29 ++
 rtl/packet_tx_scheduler.sv | 128 ++++++++++++
 tb/tb_packet_tx_scheduler.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_tx_scheduler_if.sv
// Handshake and serializer-side signals of packet_tx_scheduler.
// slave = scheduler side, master = requesters / serializer / modulator side.
interface packet_tx_scheduler_if #(
  parameter int PACKET_SIZE = 192
);
  logic                   req0;
  logic [PACKET_SIZE-1:0] pkt0;
  logic                   ack0;
  logic                   req1;
  logic [PACKET_SIZE-1:0] pkt1;
  logic                   ack1;
  logic [PACKET_SIZE-1:0] ser_packet;
  logic                   ser_clear;
  logic                   ser_next;
  logic                   mod_enable;
  logic                   busy;
  logic                   done;
  logic                   last_grant;

  modport slave (
    input  req0, pkt0, req1, pkt1, ser_next,
    output ack0, ack1, ser_packet, ser_clear, mod_enable, busy, done, last_grant
  );

  modport master (
    output req0, pkt0, req1, pkt1, ser_next,
    input  ack0, ack1, ser_packet, ser_clear, mod_enable, busy, done, last_grant
  );
endinterface

// File: rtl/packet_tx_scheduler.sv
// Two-requester packet scheduler feeding a serializer/modulator: IDLE -> LOAD -> SEND -> GAP.
// Define ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to requester 0.
module packet_tx_scheduler #(
  parameter int PACKET_SIZE = 192,
  parameter int GAP_CYCLES  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  packet_tx_scheduler_if.slave bus
);

  localparam int CW = $clog2(PACKET_SIZE + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(PACKET_SIZE - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LAST_I);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [PACKET_SIZE-1:0] ser_packet_q, ser_packet_d;
  logic                   last_grant_q, last_grant_d;
  logic                   ack0_q, ack0_d;
  logic                   ack1_q, ack1_d;
  logic                   ser_clear_q, ser_clear_d;
  logic                   mod_enable_q, mod_enable_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pick1;

`ifdef ROUND_ROBIN_EN
  // On contention, the requester that did not win last time goes next.
  assign pick1 = bus.req1 & (~bus.req0 | ~last_grant_q);
`else
  assign pick1 = bus.req1 & ~bus.req0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    ser_packet_d = ser_packet_q;
    last_grant_d = last_grant_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    ser_clear_d  = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d      = LOAD;
          last_grant_d = pick1;
          ser_packet_d = pick1 ? bus.pkt1 : bus.pkt0;
          ack0_d       = ~pick1;
          ack1_d       = pick1;
          ser_clear_d  = 1'b1;
        end
      end
      LOAD: begin
        state_d = SEND;
        cnt_d   = '0;
      end
      SEND: begin
        if (bus.ser_next) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            done_d  = 1'b1;
            gap_d   = '0;
            state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of what the next state implies (Moore).
    mod_enable_d = (state_d == SEND);
    busy_d       = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      gap_q        <= '0;
      // NOTE: the wide packet register is reset too, so ser_packet reads zero after reset.
      ser_packet_q <= '0;
      last_grant_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      ser_clear_q  <= 1'b0;
      mod_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      ser_packet_q <= ser_packet_d;
      last_grant_q <= last_grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      ser_clear_q  <= ser_clear_d;
      mod_enable_q <= mod_enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.ser_packet = ser_packet_q;
  assign bus.ser_clear  = ser_clear_q;
  assign bus.mod_enable = mod_enable_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.last_grant = last_grant_q;

endmodule

// File: tb/tb_packet_tx_scheduler.sv
// Directed bench for packet_tx_scheduler: a 192-bit/16-gap instance and an 8-bit/no-gap instance.
// Expected grants follow ROUND_ROBIN_EN when it is defined for the build.
module tb_packet_tx_scheduler;

  localparam int PS_A  = 192;
  localparam int GAP_A = 16;
  localparam int PS_B  = 8;

  localparam logic [PS_A-1:0] PKT_A0 = 192'hff5468_0123456789abcdef_fedcba9876543210_1e2d3c6521;
  localparam logic [PS_A-1:0] PKT_A1 = 192'h0a1b2c_3d4e5f6071829304_a5a5a5a55a5a5a5a_c3c3c3c3c3;
  localparam logic [PS_B-1:0] PKT_B0 = 8'h3c;
  localparam logic [PS_B-1:0] PKT_B1 = 8'ha5;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  packet_tx_scheduler_if #(.PACKET_SIZE(PS_A)) ifa ();
  packet_tx_scheduler_if #(.PACKET_SIZE(PS_B)) ifb ();

  packet_tx_scheduler #(.PACKET_SIZE(PS_A), .GAP_CYCLES(GAP_A)) dut_a (
    .clock(clock),
    .reset(reset),
    .bus  (ifa.slave)
  );

  packet_tx_scheduler #(.PACKET_SIZE(PS_B), .GAP_CYCLES(0)) dut_b (
    .clock(clock),
    .reset(reset),
    .bus  (ifb.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [PS_A-1:0] act, input logic [PS_A-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic r0;
    logic r1;
    logic e_ack0;
    logic e_ack1;
    logic e_lg;
  } vec_t;

  vec_t vecs[9];
  logic exp_held[3];

  initial begin
    logic [PS_B-1:0] exp_pkt_b;
    int acks, clrs, me_low, dones, gap_dones, busy_cycles;

`ifdef ROUND_ROBIN_EN
    vecs[0] = '{1, 1, 1, 0, 0};
    vecs[1] = '{1, 1, 0, 1, 1};
    vecs[2] = '{0, 1, 0, 1, 1};
    vecs[3] = '{0, 0, 0, 0, 1};
    vecs[4] = '{1, 1, 1, 0, 0};
    vecs[5] = '{1, 0, 1, 0, 0};
    vecs[6] = '{1, 1, 0, 1, 1};
    vecs[7] = '{0, 1, 0, 1, 1};
    vecs[8] = '{1, 1, 1, 0, 0};
    exp_held = '{0, 1, 0};
`else
    vecs[0] = '{1, 1, 1, 0, 0};
    vecs[1] = '{1, 1, 1, 0, 0};
    vecs[2] = '{0, 1, 0, 1, 1};
    vecs[3] = '{0, 0, 0, 0, 1};
    vecs[4] = '{1, 1, 1, 0, 0};
    vecs[5] = '{1, 0, 1, 0, 0};
    vecs[6] = '{1, 1, 1, 0, 0};
    vecs[7] = '{0, 1, 0, 1, 1};
    vecs[8] = '{1, 1, 1, 0, 0};
    exp_held = '{0, 0, 0};
`endif

    total = 0;
    bad   = 0;
    reset = 1'b1;
    ifa.req0 = 1'b0; ifa.req1 = 1'b0; ifa.ser_next = 1'b0;
    ifa.pkt0 = PKT_A0; ifa.pkt1 = PKT_A1;
    ifb.req0 = 1'b0; ifb.req1 = 1'b0; ifb.ser_next = 1'b0;
    ifb.pkt0 = PKT_B0; ifb.pkt1 = PKT_B1;

    // Reset state
    step();
    step();
    check("rst_ack0", ifa.ack0, 0);
    check("rst_ack1", ifa.ack1, 0);
    check("rst_ser_clear", ifa.ser_clear, 0);
    check("rst_mod_enable", ifa.mod_enable, 0);
    check("rst_done", ifa.done, 0);
    check("rst_busy", ifa.busy, 0);
    check("rst_ser_packet", ifa.ser_packet, 0);
    check("rst_last_grant", ifa.last_grant, 1);
    check("rst_last_grant_b", ifb.last_grant, 1);
    reset = 1'b0;
    step();
    check("idle_busy", ifa.busy, 0);

    // Arbitration table on the 8-bit, no-gap instance
    exp_pkt_b = '0;
    for (int i = 0; i < 9; i++) begin
      ifb.req0 = vecs[i].r0;
      ifb.req1 = vecs[i].r1;
      step();
      ifb.req0 = 1'b0;
      ifb.req1 = 1'b0;
      if (vecs[i].e_ack0 || vecs[i].e_ack1) exp_pkt_b = vecs[i].e_ack1 ? PKT_B1 : PKT_B0;
      check($sformatf("v%0d_ack0", i), ifb.ack0, vecs[i].e_ack0);
      check($sformatf("v%0d_ack1", i), ifb.ack1, vecs[i].e_ack1);
      check($sformatf("v%0d_last_grant", i), ifb.last_grant, vecs[i].e_lg);
      check($sformatf("v%0d_ser_packet", i), ifb.ser_packet, exp_pkt_b);
      check($sformatf("v%0d_ser_clear", i), ifb.ser_clear, vecs[i].e_ack0 | vecs[i].e_ack1);
      if (vecs[i].e_ack0 || vecs[i].e_ack1) begin
        step();
        ifb.ser_next = 1'b1;
        repeat (PS_B) step();
        ifb.ser_next = 1'b0;
        check($sformatf("v%0d_done", i), ifb.done, 1);
      end
    end

    // Both requests held across three packets; next ack one cycle after done
    reset = 1'b1;
    step();
    reset = 1'b0;
    ifb.req0 = 1'b1;
    ifb.req1 = 1'b1;
    step();
    for (int p = 0; p < 3; p++) begin
      check($sformatf("held%0d_ack0", p), ifb.ack0, !exp_held[p]);
      check($sformatf("held%0d_ack1", p), ifb.ack1, exp_held[p]);
      check($sformatf("held%0d_ser_packet", p), ifb.ser_packet, exp_held[p] ? PKT_B1 : PKT_B0);
      check($sformatf("held%0d_last_grant", p), ifb.last_grant, exp_held[p]);
      step();
      ifb.ser_next = 1'b1;
      repeat (PS_B) step();
      ifb.ser_next = 1'b0;
      check($sformatf("held%0d_done", p), ifb.done, 1);
      check($sformatf("held%0d_no_ack_at_done", p), ifb.ack0 | ifb.ack1, 0);
      step();
    end
    ifb.req0 = 1'b0;
    ifb.req1 = 1'b0;

    // Single 192-bit packet, ser_next every 4th cycle
    ifa.req0 = 1'b1;
    step();
    ifa.req0 = 1'b0;
    check("a1_ack0", ifa.ack0, 1);
    check("a1_ack1", ifa.ack1, 0);
    check("a1_ser_clear", ifa.ser_clear, 1);
    check("a1_ser_packet", ifa.ser_packet, PKT_A0);
    check("a1_mod_enable_load", ifa.mod_enable, 0);
    check("a1_busy", ifa.busy, 1);
    check("a1_last_grant", ifa.last_grant, 0);
    acks = int'(ifa.ack0);
    clrs = int'(ifa.ser_clear);
    step();
    check("a1_mod_enable_rise", ifa.mod_enable, 1);
    acks += int'(ifa.ack0);
    clrs += int'(ifa.ser_clear);
    me_low = 0;
    dones  = 0;
    for (int c = 0; c < 4 * PS_A; c++) begin
      ifa.ser_next = (c % 4 == 3);
      step();
      if (c < 4 * PS_A - 1) begin
        acks  += int'(ifa.ack0);
        clrs  += int'(ifa.ser_clear);
        dones += int'(ifa.done);
        if (!ifa.mod_enable) me_low++;
      end
    end
    ifa.ser_next = 1'b0;
    check("a1_mod_enable_held", me_low, 0);
    check("a1_early_done", dones, 0);
    check("a1_done", ifa.done, 1);
    check("a1_mod_enable_fall", ifa.mod_enable, 0);
    check("a1_busy_in_gap", ifa.busy, 1);
    busy_cycles = 1;
    gap_dones   = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      acks      += int'(ifa.ack0);
      clrs      += int'(ifa.ser_clear);
      gap_dones += int'(ifa.done);
      if (!ifa.busy) break;
      busy_cycles++;
    end
    check("a1_gap_len", busy_cycles, GAP_A);
    check("a1_gap_done", gap_dones, 0);
    check("a1_ack0_pulses", acks, 1);
    check("a1_ser_clear_pulses", clrs, 1);
    check("a1_ser_packet_hold", ifa.ser_packet, PKT_A0);

    // ser_next during LOAD and GAP must not count
    ifa.req1 = 1'b1;
    step();
    ifa.req1 = 1'b0;
    check("a2_ack1", ifa.ack1, 1);
    check("a2_ser_packet", ifa.ser_packet, PKT_A1);
    check("a2_last_grant", ifa.last_grant, 1);
    ifa.ser_next = 1'b1;
    step();
    repeat (PS_A - 1) step();
    check("a2_no_done_191", ifa.done, 0);
    check("a2_mod_enable_191", ifa.mod_enable, 1);
    step();
    check("a2_done_192", ifa.done, 1);
    busy_cycles = 1;
    gap_dones   = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      gap_dones += int'(ifa.done);
      if (!ifa.busy) break;
      busy_cycles++;
    end
    ifa.ser_next = 1'b0;
    check("a2_gap_len", busy_cycles, GAP_A);
    check("a2_gap_done", gap_dones, 0);

    // Reset after 100 pulses mid-SEND, then a fresh packet from requester 1
    ifa.req0 = 1'b1;
    step();
    ifa.req0 = 1'b0;
    check("a3_ack0", ifa.ack0, 1);
    ifa.ser_next = 1'b1;
    step();
    repeat (100) step();
    check("a3_mid_send", ifa.mod_enable, 1);
    reset    = 1'b1;
    ifa.req1 = 1'b1;
    step();
    check("a3_rst_ack0", ifa.ack0, 0);
    check("a3_rst_ack1", ifa.ack1, 0);
    check("a3_rst_ser_clear", ifa.ser_clear, 0);
    check("a3_rst_mod_enable", ifa.mod_enable, 0);
    check("a3_rst_done", ifa.done, 0);
    check("a3_rst_busy", ifa.busy, 0);
    check("a3_rst_ser_packet", ifa.ser_packet, 0);
    check("a3_rst_last_grant", ifa.last_grant, 1);
    reset        = 1'b0;
    ifa.ser_next = 1'b0;
    step();
    ifa.req1 = 1'b0;
    check("a3_ack1", ifa.ack1, 1);
    check("a3_ser_clear", ifa.ser_clear, 1);
    check("a3_ser_packet", ifa.ser_packet, PKT_A1);
    check("a3_busy", ifa.busy, 1);
    ifa.ser_next = 1'b1;
    step();
    repeat (PS_A - 1) step();
    check("a3_no_done_191", ifa.done, 0);
    step();
    ifa.ser_next = 1'b0;
    check("a3_done_192", ifa.done, 1);
    repeat (GAP_A) step();
    check("a3_idle_after_gap", ifa.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
